// File: rtl/main_mem.sv
// rtl/main_mem.sv - memory-side responder of the cache/memory command bus.
// MAIN_MEM_RANDOM_INIT_EN: defined -> seeded random initial contents, undefined -> all-zero contents.
module main_mem #(
    parameter int BUS_SIZE          = 16,
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int MEM_LATENCY       = 100,
    parameter int SEED              = 225526
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
    inout  wire  [BUS_SIZE-1:0]                        mem_data,
    inout  wire  [1:0]                                 mem_command
);
    localparam int LINE_ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int LINE_BITS   = CACHE_LINE_SIZE * 8;
    localparam int BEATS       = LINE_BITS / BUS_SIZE;
    localparam int BEAT_W      = $clog2(BEATS);
    localparam int NUM_LINES   = 1 << LINE_ADDR_W;
    localparam logic [7:0] LAST_WAIT = 8'(MEM_LATENCY - 1);
    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    localparam logic [1:0] CMD_RESPONSE = 2'd1;
    localparam logic [1:0] CMD_READ     = 2'd2;
    localparam logic [1:0] CMD_WRITE    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE_RX,
        S_WAIT,
        S_READ_TX,
        S_WRITE_ACK
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [7:0]                    r_cnt;
    logic [7:0]                    w_next_cnt;
    logic [LINE_ADDR_W-1:0]        r_addr;
    logic                          r_is_write;
    logic [LINE_BITS-BUS_SIZE-1:0] r_wbuf;
    logic [LINE_BITS-1:0]          r_mem [NUM_LINES];

    logic                          w_cmd_read;
    logic                          w_cmd_write;
    logic                          w_commit;
    logic                          w_drive_cmd;
    logic                          w_drive_data;
    logic [LINE_BITS-1:0]          w_rd_line;
    logic [BUS_SIZE-1:0]           w_rd_beat;

    assign w_cmd_read  = (mem_command == CMD_READ);
    assign w_cmd_write = (mem_command == CMD_WRITE);

`ifdef MAIN_MEM_RANDOM_INIT_EN
    integer r_seed;
    initial begin
        r_seed = SEED;
        for (int j = 0; j < NUM_LINES * CACHE_LINE_SIZE; j++)
            r_mem[LINE_ADDR_W'(j / CACHE_LINE_SIZE)][(j % CACHE_LINE_SIZE) * 8 +: 8] = 8'($random(r_seed) & 8'hFF);
    end
`else
    initial begin
        for (int n = 0; n < NUM_LINES; n++)
            r_mem[LINE_ADDR_W'(n)] = '0;
    end
`endif

    // The counter holds cycles elapsed since the command edge, then the beat index once transmitting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_wbuf     <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (r_state == S_IDLE && (w_cmd_read || w_cmd_write)) begin
                r_addr     <= mem_address;
                r_is_write <= w_cmd_write;
            end
            for (int b = 0; b < BEATS - 1; b++) begin
                if ((r_state == S_IDLE && w_cmd_write && b == 0) ||
                    (r_state == S_WRITE_RX && r_cnt == 8'(b)))
                    r_wbuf[b * BUS_SIZE +: BUS_SIZE] <= mem_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 8'd1;
        w_commit     = 1'b0;
        w_drive_cmd  = 1'b0;
        w_drive_data = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_cnt = 8'd1;
                if (w_cmd_read)
                    w_next_state = S_WAIT;
                else if (w_cmd_write)
                    w_next_state = S_WRITE_RX;
                else
                    w_next_cnt = '0;
            end
            S_WRITE_RX: begin
                if (r_cnt == LAST_BEAT) begin
                    w_commit     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == LAST_WAIT) begin
                    w_next_state = r_is_write ? S_WRITE_ACK : S_READ_TX;
                    w_next_cnt   = '0;
                end
            end
            S_READ_TX: begin
                w_drive_cmd  = 1'b1;
                w_drive_data = 1'b1;
                if (r_cnt == LAST_BEAT) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end
            end
            S_WRITE_ACK: begin
                w_drive_cmd  = 1'b1;
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Last beat goes straight from the bus into the array, so a following read sees it.
    always @(posedge clk) begin
        if (w_commit)
            r_mem[r_addr] <= {mem_data, r_wbuf};
    end

    assign w_rd_line = r_mem[r_addr];
    assign w_rd_beat = w_rd_line[r_cnt[BEAT_W-1:0] * BUS_SIZE +: BUS_SIZE];

    assign mem_command = w_drive_cmd  ? CMD_RESPONSE : {2{1'bz}};
    assign mem_data    = w_drive_data ? w_rd_beat    : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_main_mem.sv
// tb/tb_main_mem.sv - directed self-checking bench for main_mem (latency 100 and latency 9 instances).
module tb_main_mem;
    localparam int LAT0 = 100;
    localparam int LAT1 = 9;
    localparam logic [1:0] C_NOP = 2'd0;
    localparam logic [1:0] C_RSP = 2'd1;
    localparam logic [1:0] C_RD  = 2'd2;
    localparam logic [1:0] C_WR  = 2'd3;
    // A released data bus reads back as the pull-up value, a released command bus as NOP.
    localparam logic [15:0] DZ = 16'hFFFF;

    localparam logic [127:0] W1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [127:0] W2 = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
    localparam logic [127:0] P0 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1357_2468;
    localparam logic [127:0] W3 = 128'hCAFE_0007_0006_0005_0004_0003_0002_0001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] addr   [2];
    logic [1:0]  cmd    [2];
    logic        cmd_en [2];
    logic [15:0] dat    [2];
    logic        dat_en [2];

    wire [15:0] md0, md1;
    wire [1:0]  mc0, mc1;

    for (genvar b = 0; b < 16; b++) begin : g_pu
        pullup (md0[b]);
        pullup (md1[b]);
    end
    for (genvar b = 0; b < 2; b++) begin : g_pd
        pulldown (mc0[b]);
        pulldown (mc1[b]);
    end

    assign md0 = dat_en[0] ? dat[0] : 16'bz;
    assign md1 = dat_en[1] ? dat[1] : 16'bz;
    assign mc0 = cmd_en[0] ? cmd[0] : 2'bz;
    assign mc1 = cmd_en[1] ? cmd[1] : 2'bz;

    main_mem #(.MEM_LATENCY(LAT0)) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .mem_address (addr[0]),
        .mem_data    (md0),
        .mem_command (mc0)
    );

    main_mem #(.MEM_LATENCY(LAT1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .mem_address (addr[1]),
        .mem_data    (md1),
        .mem_command (mc1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bus_d(input int s);
        return (s != 0) ? md1 : md0;
    endfunction

    function automatic logic [1:0] bus_c(input int s);
        return (s != 0) ? mc1 : mc0;
    endfunction

    function automatic logic [127:0] ref_line(input int n);
        logic [127:0] l = '0;
`ifdef MAIN_MEM_RANDOM_INIT_EN
        integer sd = 225526;
        logic [7:0] bv;
        for (int j = 0; j < (n + 1) * 16; j++) begin
            bv = 8'($random(sd) & 8'hFF);
            if (j >= n * 16)
                l[(j % 16) * 8 +: 8] = bv;
        end
`endif
        return l;
    endfunction

    // inj > 0 drives a WRITE command on the bus at cycle T+inj and T+inj+1 of the read.
    task automatic read_check(input int s, input int lat, input logic [14:0] a,
                              input logic [127:0] exp, input string tag, input int inj);
        @(negedge clk);
        addr[s] = a; cmd[s] = C_RD; cmd_en[s] = 1'b1;
        @(posedge clk);
        #1 cmd_en[s] = 1'b0;
        for (int j = 1; j <= lat + 8; j++) begin
            @(negedge clk);
            if (inj > 0 && j == inj) begin
                addr[s] = 15'h0044; cmd[s] = C_WR; cmd_en[s] = 1'b1;
            end
            if (inj > 0 && j == inj + 2)
                cmd_en[s] = 1'b0;
            #1;
            if (j == 1 || j == lat - 1 || j == lat + 8) begin
                chk($sformatf("%s_z_cmd_T+%0d", tag, j), 32'(bus_c(s)), 32'(C_NOP));
                chk($sformatf("%s_z_data_T+%0d", tag, j), 32'(bus_d(s)), 32'(DZ));
            end else if (j >= lat) begin
                if (!(inj > 0 && j >= inj && j <= inj + 1))
                    chk($sformatf("%s_rsp_T+%0d", tag, j), 32'(bus_c(s)), 32'(C_RSP));
                chk($sformatf("%s_beat%0d", tag, j - lat), 32'(bus_d(s)), 32'(exp[(j - lat) * 16 +: 16]));
            end
        end
    endtask

    task automatic write_line(input int s, input int lat, input logic [14:0] a,
                              input logic [127:0] line, input string tag);
        @(negedge clk);
        addr[s] = a; cmd[s] = C_WR; cmd_en[s] = 1'b1;
        dat[s] = line[15:0]; dat_en[s] = 1'b1;
        @(posedge clk);
        #1 cmd_en[s] = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            dat[s] = line[i * 16 +: 16];
        end
        for (int j = 8; j <= lat + 1; j++) begin
            @(negedge clk);
            dat_en[s] = 1'b0;
            #1;
            if (j == 8 || j == lat - 1 || j == lat + 1) begin
                chk($sformatf("%s_z_cmd_T+%0d", tag, j), 32'(bus_c(s)), 32'(C_NOP));
                chk($sformatf("%s_z_data_T+%0d", tag, j), 32'(bus_d(s)), 32'(DZ));
            end else if (j == lat) begin
                chk($sformatf("%s_ack_cmd", tag), 32'(bus_c(s)), 32'(C_RSP));
                chk($sformatf("%s_ack_data_z", tag), 32'(bus_d(s)), 32'(DZ));
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0; cmd[s] = C_NOP; cmd_en[s] = 1'b0; dat[s] = '0; dat_en[s] = 1'b0;
        end
        #22;
        chk("rst_cmd0", 32'(mc0), 32'(C_NOP));
        chk("rst_data0", 32'(md0), 32'(DZ));
        chk("rst_cmd1", 32'(mc1), 32'(C_NOP));
        chk("rst_data1", 32'(md1), 32'(DZ));
        @(posedge clk);
        #1 reset = 1'b1;

        read_check(0, LAT0, 15'h0000, ref_line(0), "init_l0", 0);
        read_check(0, LAT0, 15'h0010, ref_line(16), "init_l10", 0);
        write_line(0, LAT0, 15'h0010, W1, "wr_l10");
        read_check(0, LAT0, 15'h0010, W1, "rd_l10", 0);

        // reset during beat 3 of a read
        @(negedge clk);
        addr[0] = 15'h0010; cmd[0] = C_RD; cmd_en[0] = 1'b1;
        @(posedge clk);
        #1 cmd_en[0] = 1'b0;
        repeat (LAT0 + 3) @(negedge clk);
        #1;
        chk("abort_rd_beat3_cmd", 32'(mc0), 32'(C_RSP));
        chk("abort_rd_beat3_data", 32'(md0), 32'(W1[63:48]));
        reset = 1'b0;
        #1;
        chk("abort_rd_cmd_z", 32'(mc0), 32'(C_NOP));
        chk("abort_rd_data_z", 32'(md0), 32'(DZ));
        @(negedge clk);
        #1;
        chk("abort_rd_cmd_z_next", 32'(mc0), 32'(C_NOP));
        chk("abort_rd_data_z_next", 32'(md0), 32'(DZ));
        @(posedge clk);
        #1 reset = 1'b1;
        read_check(0, LAT0, 15'h0010, W1, "post_rst_rd", 0);

        // reset during beat 4 of a write: line keeps W1
        @(negedge clk);
        addr[0] = 15'h0010; cmd[0] = C_WR; cmd_en[0] = 1'b1;
        dat[0] = W2[15:0]; dat_en[0] = 1'b1;
        @(posedge clk);
        #1 cmd_en[0] = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            dat[0] = W2[i * 16 +: 16];
        end
        @(negedge clk);
        dat[0] = W2[79:64];
        reset = 1'b0;
        #1;
        chk("abort_wr_cmd", 32'(mc0), 32'(C_NOP));
        @(negedge clk);
        dat_en[0] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        read_check(0, LAT0, 15'h0010, W1, "abort_wr_rd", 0);

        write_line(0, LAT0, 15'h0000, P0, "wr_l0");
        read_check(0, LAT0, 15'h7FFF, ref_line(32'h7FFF), "rd_l7fff", 0);
        read_check(0, LAT0, 15'h0000, P0, "rd_l0_inj", LAT0 + 2);
        read_check(0, LAT0, 15'h0044, ref_line(32'h44), "rd_l44", 0);

        write_line(1, LAT1, 15'h0005, W3, "lat9_wr");
        read_check(1, LAT1, 15'h0005, W3, "lat9_rd", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_mem.md
MAIN_MEM -- requirements
Module: main_mem

Interface
REQ-001 Parameters SHALL be: BUS_SIZE, 16, data-bus width in bits; MEM_ADDR_SIZE, 19, byte-address width; CACHE_OFFSET_SIZE, 4, log2 line bytes; CACHE_LINE_SIZE, 16, line bytes; MEM_LATENCY, 100, command-to-response cycles (legal range 9..255); SEED, 225526, init seed.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 mem_address  input  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  line address from cache.
REQ-005 mem_data  inout  BUS_SIZE  shared data bus.
REQ-006 mem_command  inout  2  shared command bus: NOP=0, RESPONSE=1, READ=2, WRITE=3.

Function
REQ-007 Block SHALL be the memory-side responder of the cache-to-memory command bus, storing 2^(MEM_ADDR_SIZE-CACHE_OFFSET_SIZE) lines of CACHE_LINE_SIZE bytes.
REQ-008 States SHALL be IDLE, WRITE_RX, WAIT, READ_TX, WRITE_ACK; one cycle counter of 8 bits.
REQ-009 In IDLE, WAIT and WRITE_RX, block SHALL drive mem_data and mem_command to high-impedance.
REQ-010 IDLE: posedge sampling READ (cycle T) SHALL latch mem_address, go WAIT, target READ_TX.
REQ-011 IDLE: posedge sampling WRITE (cycle T) SHALL latch mem_address, store mem_data as beat 0, go WRITE_RX.
REQ-012 IDLE: NOP or RESPONSE SHALL be ignored.
REQ-013 WRITE_RX: posedges T+1..T+7 SHALL capture beats 1..7; beat i fills line bits [16i+15:16i] (byte 2i in low half); after beat 7 the line is committed and state goes WAIT.
REQ-014 WAIT SHALL hold until posedge T+MEM_LATENCY-1, then go READ_TX (read) or WRITE_ACK (write).
REQ-015 READ_TX: during cycles T+MEM_LATENCY..T+MEM_LATENCY+7 block SHALL drive mem_command=RESPONSE and mem_data=beat 0..7, one beat per cycle, then release both buses and return to IDLE.
REQ-016 WRITE_ACK: during cycle T+MEM_LATENCY block SHALL drive mem_command=RESPONSE with mem_data high-impedance, then release and return to IDLE.
REQ-017 Commands sampled outside IDLE SHALL be ignored; the transaction in progress completes unchanged.
REQ-018 Line address SHALL wrap modulo line count; no out-of-range access.
REQ-019 Read issued immediately after a write to the same line SHALL return the newly written data.

Reset
REQ-020 reset=0 SHALL immediately force state IDLE, counter 0, mem_data and mem_command high-impedance.
REQ-021 reset mid-transaction SHALL abort it: partial WRITE_RX beats discarded, line unchanged; READ_TX stops at once.
REQ-022 Memory contents SHALL NOT be altered by reset.
REQ-023 First command SHALL be sampled at the first posedge after reset deasserts.

Configuration
REQ-024 Macro MAIN_MEM_RANDOM_INIT_EN SHALL select initial contents.
REQ-025 Defined: at time 0, byte j (ascending j) SHALL be set to $random(seed) & 8'hFF, seed variable initialised from SEED.
REQ-026 Undefined: all bytes SHALL initialise to 8'h00.

Verification
REQ-027 Macro undefined; READ line 0x0010 at cycle T -> buses Z until T+99; RESPONSE with data 0x0000 for exactly 8 cycles T+100..T+107; Z at T+108.
REQ-028 WRITE line 0x0010 beats 0x1111,0x2222,...,0x8888 at T..T+7 -> single RESPONSE cycle at T+100, mem_data Z; subsequent READ of 0x0010 returns 0x1111..0x8888 in order.
REQ-029 WRITE during READ_TX of another line -> ignored; read beats unaffected; target line still reads old data.
REQ-030 reset=0 asserted at beat 3 of READ_TX -> buses Z same cycle, IDLE; reset asserted during WRITE_RX beat 4 -> line retains prior content.
REQ-031 READ line 0x7FFF and write/read line 0x0000 -> independent data, no aliasing; MEM_LATENCY=9 -> first read beat at T+9.
REQ-032 Macro defined, SEED=225526 -> two simulations produce identical read data for line 0x0000, matching bench reference model.
